// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester arbiter/sequencer for a 256Kx16 asynchronous SRAM.
//
// Requester A (CPU bus bridge) and requester B (video pixel fetch) share the
// SRAM.
// - One single-word access per grant.
// - Completion is a one-cycle ack; read data is valid while ack is high.
// - A and B are served round robin when both request in the same IDLE cycle.
//
// Optional build macro: SRAM_ARB_FIXED_PRIO_EN
//   Defined:   B (video) always wins a simultaneous request; A may starve.
//   Undefined: round robin arbitration (default).
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  requester A request, direction, address, write data
//   a_be                       A byte enables ([1]=upper, [0]=lower)
//   a_ack/a_rdata              A completion pulse and read data
//   b_*                        same set of signals for requester B
//   busy                       high whenever the sequencer is not IDLE
//   SRAM_ADDR/SRAM_DQ          SRAM address and bidirectional data bus
//   SRAM_*_N                   active-low SRAM strobes (CE, OE, WE, UB, LB)
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_W        = 18,
  parameter int DATA_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [1:0]        a_be,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [1:0]        b_be,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic       GNT_A    = 1'b0;
  localparam logic       GNT_B    = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          be_q, be_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic                busy_q, busy_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                ub_n_q, ub_n_d;
  logic                lb_n_q, lb_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic                pick;
  logic                acc_next;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    pick      = GNT_A;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          if (a_req && b_req) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            pick = GNT_B;
`else
            pick = ~last_q;
`endif
          end else begin
            pick = b_req ? GNT_B : GNT_A;
          end
          gnt_d   = pick;
          we_d    = pick ? b_we    : a_we;
          addr_d  = pick ? b_addr  : a_addr;
          wdata_d = pick ? b_wdata : a_wdata;
          be_d    = pick ? b_be    : a_be;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Last strobe cycle: read data has settled on the bus.
          if (!we_q) begin
            if (gnt_q) b_rdata_d = SRAM_DQ;
            else       a_rdata_d = SRAM_DQ;
          end
          a_ack_d = (gnt_q == GNT_A);
          b_ack_d = (gnt_q == GNT_B);
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they change cleanly
    // on the same edge as the state, with no decode glitches at the pins.
    acc_next = (state_d == ACCESS);
    ce_n_d   = ~acc_next;
    oe_n_d   = ~(acc_next & ~we_d);
    we_n_d   = ~(acc_next & we_d);
    ub_n_d   = ~(acc_next & be_d[1]);
    lb_n_d   = ~(acc_next & be_d[0]);
    dq_oe_d  = acc_next & we_d;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      gnt_q     <= GNT_A;
      last_q    <= GNT_B;
      addr_q    <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      busy_q    <= busy_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      ub_n_q    <= ub_n_d;
      lb_n_q    <= lb_n_d;
      dq_oe_q   <= dq_oe_d;
    end
    // Datapath registers: only meaningful while an access is in flight.
    we_q    <= we_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign busy      = busy_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;
  // Bus is driven only during a write access; released in ACK for turnaround.
  assign SRAM_DQ   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: bench for sram_arbiter with a behavioural SRAM, a
// timestamp-based arbitration model and a word-array reference memory.
module tb_sram_arbiter;

  localparam int AC = 2;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic [1:0]    a_be = '0, b_be = '0;
  logic          a_ack, b_ack, busy;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;
  logic          ce_n, oe_n, we_n, ub_n, lb_n;

  always #10 clk = ~clk;

  sram_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .busy(busy), .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural SRAM ----------------
  // Enabled bytes are returned on reads; while the chip is deselected the
  // bench holds the bus at zero so any stray drive from the DUT shows up.
  logic [DW-1:0] sram    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic          tb_drv_en;
  logic [DW-1:0] tb_drv_val;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]    <= '0;
      ref_mem[i] <= '0;
    end
  end

  always @* begin
    tb_drv_en  = 1'b0;
    tb_drv_val = '0;
    if (ce_n) begin
      tb_drv_en = 1'b1;
    end else if (!oe_n && we_n) begin
      tb_drv_en  = 1'b1;
      tb_drv_val = sram[sram_addr] & {{8{~ub_n}}, {8{~lb_n}}};
    end
  end

  assign sram_dq = tb_drv_en ? tb_drv_val : {DW{1'bz}};

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) sram[sram_addr][7:0]  <= sram_dq[7:0];
      if (!ub_n) sram[sram_addr][15:8] <= sram_dq[15:8];
    end
  end

  // ---------------- reference model ----------------
  // e counts clock edges. A grant sampled at edge S occupies the SRAM for
  // edges S..S+AC-1, acks after edge S+AC, and the next grant can be
  // sampled no earlier than edge S+AC+2.
  int            e = 0;
  bit            armed = 1'b0;
  bit            m_pend = 1'b0;
  int            m_start = 0, m_free = 0;
  logic          m_g = 1'b0, m_last = 1'b1, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0, m_ard = '0, m_brd = '0;
  logic [1:0]    m_be = '0;

  always @(posedge clk) begin
    e     <= e + 1;
    armed <= armed | reset;
    if (reset) begin
      m_pend <= 1'b0;
      m_last <= 1'b1;
      m_free <= e + 2;
      m_ard  <= '0;
      m_brd  <= '0;
    end else begin
      if (m_pend && (e + 1 == m_start + AC)) begin
        if (m_we)
          ref_mem[m_addr] <= {m_be[1] ? m_wd[15:8] : ref_mem[m_addr][15:8],
                              m_be[0] ? m_wd[7:0]  : ref_mem[m_addr][7:0]};
        else if (m_g)
          m_brd <= ref_mem[m_addr] & {{8{m_be[1]}}, {8{m_be[0]}}};
        else
          m_ard <= ref_mem[m_addr] & {{8{m_be[1]}}, {8{m_be[0]}}};
      end
      if (m_pend && (e + 1 == m_start + AC + 1)) begin
        m_pend <= 1'b0;
        m_last <= m_g;
      end
      if (!m_pend && (e + 1 >= m_free) && (a_req || b_req)) begin
        logic g;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        g = (a_req && b_req) ? 1'b1 : b_req;
`else
        g = (a_req && b_req) ? ~m_last : b_req;
`endif
        m_g     <= g;
        m_we    <= g ? b_we    : a_we;
        m_addr  <= g ? b_addr  : a_addr;
        m_wd    <= g ? b_wdata : a_wdata;
        m_be    <= g ? b_be    : a_be;
        m_pend  <= 1'b1;
        m_start <= e + 1;
        m_free  <= e + 1 + AC + 2;
      end
    end
  end

  logic exp_acc, exp_ack;
  assign exp_acc = m_pend && (e >= m_start) && (e <= m_start + AC - 1);
  assign exp_ack = m_pend && (e == m_start + AC);

  always @(negedge clk) begin
    if (armed) begin
      check("strobes", {ce_n, oe_n, we_n, ub_n, lb_n},
            exp_acc ? {1'b0, m_we, ~m_we, ~m_be[1], ~m_be[0]} : 5'h1f);
      check("oe_we_excl", oe_n | we_n, 1);
      if (exp_acc) check("addr", sram_addr, m_addr);
      if (exp_acc && m_we) check("dq_write", sram_dq, m_wd);
      if (ce_n) check("dq_released", sram_dq, 0);
      check("a_ack", a_ack, exp_ack && !m_g);
      check("b_ack", b_ack, exp_ack && m_g);
      check("busy", busy, m_pend);
      check("a_rdata", a_rdata, m_ard);
      check("b_rdata", b_rdata, m_brd);
    end
  end

  // ---------------- requester drivers ----------------
  task automatic xfer(input bit who, input bit we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [1:0] be, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    @(negedge clk);
    if (!who) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_be = be;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; b_be = be;
    end
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = who ? b_ack : a_ack;
    end
    if (!got) check(who ? "b_ack_wait" : "a_ack_wait", got, 1);
  endtask

  task automatic rel(input bit who);
    @(negedge clk);
    if (!who) a_req = 1'b0;
    else      b_req = 1'b0;
  endtask

  task automatic rand_requester(input bit who, input int n);
    int lat, g;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, 3);
      if (g > 0) begin
        rel(who);
        repeat (g - 1) @(negedge clk);
      end
      xfer(who, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
           DW'($urandom), 2'($urandom_range(0, 3)), lat);
    end
    rel(who);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat, na, nb;
    bit first_b;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1f);
    check("rst_busy", busy, 0);
    check("rst_acks", {a_ack, b_ack}, 0);
    check("rst_rdata", {a_rdata, b_rdata}, 0);
    check("rst_addr", sram_addr, 0);

    xfer(0, 1, 18'h00010, 16'hBEEF, 2'b11, lat);
    check("wr_lat", lat, AC + 1);
    rel(0);
    xfer(0, 0, 18'h00010, 16'h0000, 2'b11, lat);
    check("rd_lat", lat, AC + 1);
    check("rd_beef", a_rdata, 16'hBEEF);
    rel(0);

    xfer(0, 1, 18'h3FFFF, 16'hABCD, 2'b11, lat);
    rel(0);
    xfer(0, 1, 18'h3FFFF, 16'h1234, 2'b01, lat);
    rel(0);
    xfer(0, 0, 18'h3FFFF, 16'h0000, 2'b11, lat);
    check("byte_rd", a_rdata, 16'hAB34);
    rel(0);

    // be=00 write must still complete but leave memory untouched.
    xfer(1, 1, 18'h00010, 16'h5555, 2'b00, lat);
    check("be0_lat", lat, AC + 1);
    rel(1);
    xfer(1, 0, 18'h00010, 16'h0000, 2'b11, lat);
    check("be0_keep", b_rdata, 16'hBEEF);
    check("a_hold", a_rdata, 16'hAB34);
    rel(1);

    // Both requesters held high for six accesses.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 18'h00010; a_be = 2'b11;
    b_req = 1'b1; b_we = 1'b0; b_addr = 18'h3FFFF; b_be = 2'b11;
    na = 0; nb = 0;
    for (int i = 0; i < 200 && (na + nb) < 6; i++) begin
      @(negedge clk);
      na += int'(a_ack);
      nb += int'(b_ack);
    end
    check("six_acks", na + nb, 6);
`ifdef SRAM_ARB_FIXED_PRIO_EN
    check("a_acks", na, 0);
`else
    check("a_acks", na, 3);
`endif
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during the second ACCESS cycle of a write.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 18'h2AAAA; a_wdata = 16'h5A5A; a_be = 2'b11;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1f);
    check("abort_busy", busy, 0);
    check("abort_acks", {a_ack, b_ack}, 0);
    check("abort_dq", sram_dq, 0);
    reset = 1'b0;
    a_we = 1'b0; a_addr = 18'h00010;
    b_req = 1'b1; b_we = 1'b0; b_addr = 18'h00010; b_be = 2'b11;
    lat = 0;
    for (int i = 0; i < 50 && !(a_ack || b_ack); i++) @(negedge clk);
`ifdef SRAM_ARB_FIXED_PRIO_EN
    check("first_after_rst", {a_ack, b_ack}, 2'b01);
`else
    check("first_after_rst", {a_ack, b_ack}, 2'b10);
`endif
    first_b = b_ack;
    @(negedge clk);
    if (first_b) b_req = 1'b0;
    else         a_req = 1'b0;
    for (int i = 0; i < 50 && !(first_b ? a_ack : b_ack); i++) @(negedge clk);
    check("second_after_rst", {a_ack, b_ack}, first_b ? 2'b10 : 2'b01);
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);

    // Randomised concurrent traffic from both requesters.
    fork
      rand_requester(0, 40);
      rand_requester(1, 40);
    join
    repeat (6) @(negedge clk);
    check("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
